demux_striping: RTL
===================

// Module: demux_striping
// PURPOSE
//  - Upstream neighbour of the lane-merge stage: splits one 32-bit word stream at clk_2f into two lanes.
//  - Even words go to lane_0 and odd words go to lane_1; each pair is published on both lanes together.
//  - Lane outputs hold for two clk_2f cycles, so the merge stage reads lane_0 and then lane_1 on consecutive edges.
//  - Feeds the merge stage's lane_0/lane_1/valid_0/valid_1 inputs directly.
// PARAMETERS
//  - DATA_WIDTH  32  word width of data_in, lane_0 and lane_1
// PORTS
//  - clk_2f    in   1           single clock, double-rate domain
//  - reset     in   1           asynchronous, active-high; all state cleared while high
//  - data_in   in   DATA_WIDTH  input word, sampled only when valid_in=1
//  - valid_in  in   1           data_in carries a word this cycle; no backpressure
//  - lane_0    out  DATA_WIDTH  even word of the current pair
//  - lane_1    out  DATA_WIDTH  odd word of the current pair
//  - valid_0   out  1           lane_0 holds a published word
//  - valid_1   out  1           lane_1 holds a published word
// BEHAVIOUR
//  - Reset (async, high): state=S_EVEN; stage, lane_0, lane_1, hold all 0; valid_0=valid_1=0.
//  - A staged word is discarded on reset, including mid-pair.
//  - FSM states: S_EVEN (waiting for even word), S_ODD (even word held in stage).
//  - S_EVEN, valid_in=1: stage<=data_in; go to S_ODD. Lane outputs are not touched.
//  - S_EVEN, valid_in=0: remain in S_EVEN.
//  - S_ODD, valid_in=1 (pair update):
//      lane_0<=stage, lane_1<=data_in, valid_0<=1, valid_1<=1, hold<=1; go to S_EVEN.
//  - S_ODD, valid_in=0 (partial flush):
//      lane_0<=stage, valid_0<=1, valid_1<=0, lane_1 unchanged, hold<=1; go to S_EVEN.
//      An odd-length burst is never stranded.
//  - Hold rule, on edges with no update:
//      hold=1 -> hold<=0, valids keep their value.
//      hold=0 -> valid_0<=0, valid_1<=0; lane data keeps its value.
//  - Net effect: each publish keeps the valids high for exactly 2 cycles.
//  - Continuous stream (valid_in high every cycle): an update occurs every 2nd edge and valids stay high with no gap.
//  - Latency: lanes update on the same edge that samples the odd word. Even word appears 1 cycle after it is sampled.
//  - An update edge always takes priority over hold expiry.
// CONFIGURATION
//  - Macro STRIPE_PARITY_EN.
//  - Defined: adds outputs parity_0 and parity_1 (1 bit each).
//      Each is the even parity (^lane_x) of its lane, registered on the same edge as the lane data.
//      Reset value 0.
//      parity_1 is recomputed on a partial flush from the unchanged lane_1.
//  - Undefined: the parity ports and logic are absent; all other behaviour is identical.
// STRUCTURE
//  - Package striping_pkg:
//      STRIPE_DW=32 (default for DATA_WIDTH)
//      state enum {S_EVEN=1'b0, S_ODD=1'b1}
//      HOLD_CYCLES=2
//    Shared with the merge stage.
//  - No sub-module. FSM, stage register and hold counter live in one always block.
//  - Parity is an inline reduction XOR under `ifdef.
// TESTING
//  - Reset mid-pair:
//      stimulus: reset, then valid_in=1 data_in=32'hA0 (state S_ODD), then assert reset.
//      required: outputs 0 immediately. After release, 32'hB1 then 32'hC2 give lane_0=B1, lane_1=C2.
//  - Continuous burst:
//      stimulus: 8 words 1..8 back-to-back.
//      required: pairs (1,2),(3,4),(5,6),(7,8); valid_0/valid_1 high for 8 contiguous cycles starting on the edge that samples 2.
//  - Odd burst:
//      stimulus: words 5,6,7, then valid_in=0.
//      required: (5,6) published; next edge lane_0=7, valid_0=1, valid_1=0, lane_1=6; both valids low 2 cycles later.
//  - Gapped input:
//      stimulus: 1, idle, idle, 2.
//      required: the idle edge after 1 is a partial flush (lane_0=1); 2 is staged, not published, until the next word or idle.
//  - Back-to-back with merge model:
//      stimulus: chain this block into the merge stage; random stream of 1000 words with 20% idle.
//      required: merge output sequence equals input sequence, no word duplicated or dropped.
//  - STRIPE_PARITY_EN:
//      stimulus: pair (32'h00000001, 32'h00000003).
//      required: parity_0=1, parity_1=0 on the update edge.

Source files
------------

// File: rtl/striping_pkg.sv
// Package: striping_pkg
// Shared definitions for the striping demux and the lane-merge stage.
//   STRIPE_DW    default word width for both stages
//   state_e      demux pairing state (S_EVEN: waiting for even word, S_ODD: even word staged)
//   HOLD_CYCLES  number of clk_2f cycles a published pair stays valid
package striping_pkg;

  localparam int unsigned STRIPE_DW = 32;

  typedef enum logic {
    S_EVEN = 1'b0,
    S_ODD  = 1'b1
  } state_e;

  localparam int unsigned HOLD_CYCLES = 2;

  // Hold counter width; at least one bit even for tiny hold lengths.
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;

  // Value loaded into the hold counter on a publish edge. The publish edge itself
  // is the first valid cycle, so the counter covers the remaining ones.
  function automatic logic [HOLD_W-1:0] hold_reload();
    return HOLD_W'(HOLD_CYCLES - 1);
  endfunction

endpackage

// File: rtl/demux_striping.sv
// Module: demux_striping
// Splits one word stream at clk_2f into two lanes for the lane-merge stage.
// Even words go to lane_0, odd words to lane_1; each pair is published on both
// lanes on the same edge and held valid for HOLD_CYCLES cycles so the merge stage
// can read lane_0 then lane_1 on consecutive edges. An even word with no odd
// partner on the following cycle is flushed alone (valid_1 low).
//
// Ports:
//   clk_2f    in   double-rate clock
//   reset     in   asynchronous, active-high; clears all state
//   data_in   in   input word, sampled when valid_in=1
//   valid_in  in   data_in carries a word this cycle (no backpressure)
//   lane_0    out  even word of the current pair
//   lane_1    out  odd word of the current pair
//   valid_0   out  lane_0 holds a published word
//   valid_1   out  lane_1 holds a published word
//   parity_0  out  ^lane_0, only with STRIPE_PARITY_EN defined
//   parity_1  out  ^lane_1, only with STRIPE_PARITY_EN defined
//
// Configuration: define STRIPE_PARITY_EN to add the registered lane parity outputs.
module demux_striping
  import striping_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = STRIPE_DW
) (
  input  logic                  clk_2f,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] lane_0,
  output logic [DATA_WIDTH-1:0] lane_1,
  output logic                  valid_0,
`ifdef STRIPE_PARITY_EN
  output logic                  valid_1,
  output logic                  parity_0,
  output logic                  parity_1
`else
  output logic                  valid_1
`endif
);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   stage_q, stage_d;
  logic [DATA_WIDTH-1:0]   lane0_q, lane0_d;
  logic [DATA_WIDTH-1:0]   lane1_q, lane1_d;
  logic                    valid0_q, valid0_d;
  logic                    valid1_q, valid1_d;
  logic [HOLD_W-1:0]       hold_q, hold_d;
  logic                    update;
`ifdef STRIPE_PARITY_EN
  logic                    parity0_q, parity0_d;
  logic                    parity1_q, parity1_d;
`endif

  // State register: FSM, stage, lanes and hold counter together.
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      state_q   <= S_EVEN;
      stage_q   <= '0;
      lane0_q   <= '0;
      lane1_q   <= '0;
      valid0_q  <= 1'b0;
      valid1_q  <= 1'b0;
      hold_q    <= '0;
`ifdef STRIPE_PARITY_EN
      parity0_q <= 1'b0;
      parity1_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      lane0_q   <= lane0_d;
      lane1_q   <= lane1_d;
      valid0_q  <= valid0_d;
      valid1_q  <= valid1_d;
      hold_q    <= hold_d;
`ifdef STRIPE_PARITY_EN
      parity0_q <= parity0_d;
      parity1_q <= parity1_d;
`endif
    end
  end

  // Every edge in S_ODD publishes: either a full pair or a lone even word.
  assign update = (state_q == S_ODD);

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    lane0_d   = lane0_q;
    lane1_d   = lane1_q;
    valid0_d  = valid0_q;
    valid1_d  = valid1_q;
    hold_d    = hold_q;
`ifdef STRIPE_PARITY_EN
    parity0_d = parity0_q;
    parity1_d = parity1_q;
`endif

    unique case (state_q)
      S_EVEN: begin
        if (valid_in) begin
          stage_d = data_in;
          state_d = S_ODD;
        end
      end
      S_ODD: begin
        lane0_d  = stage_q;
        valid0_d = 1'b1;
        hold_d   = hold_reload();
        state_d  = S_EVEN;
`ifdef STRIPE_PARITY_EN
        parity0_d = ^stage_q;
`endif
        if (valid_in) begin
          lane1_d  = data_in;
          valid1_d = 1'b1;
`ifdef STRIPE_PARITY_EN
          parity1_d = ^data_in;
`endif
        end else begin
          // Partial flush: lane_1 keeps its old data but is no longer valid.
          valid1_d = 1'b0;
`ifdef STRIPE_PARITY_EN
          parity1_d = ^lane1_q;
`endif
        end
      end
    endcase

    // Hold expiry only on edges that do not publish; a publish always wins.
    if (!update) begin
      if (hold_q != '0) begin
        hold_d = hold_q - 1'b1;
      end else begin
        valid0_d = 1'b0;
        valid1_d = 1'b0;
      end
    end
  end

  // Outputs straight from registers.
  always_comb begin
    lane_0   = lane0_q;
    lane_1   = lane1_q;
    valid_0  = valid0_q;
    valid_1  = valid1_q;
`ifdef STRIPE_PARITY_EN
    parity_0 = parity0_q;
    parity_1 = parity1_q;
`endif
  end

endmodule
